// File: rtl/mmss_timer_ctrl_pkg.sv
// Shared types and constants for the MM:SS stopwatch / countdown controller.
// Included by the prescaler and the top-level sequencer.
package mmss_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] MAX_MS    = 6'd59;
  localparam logic       MODE_UP   = 1'b0;
  localparam logic       MODE_DOWN = 1'b1;

  // Preset fields outside 0..59 saturate to 59.
  function automatic logic [5:0] clamp_ms(input logic [5:0] v);
    return (v > MAX_MS) ? MAX_MS : v;
  endfunction

endpackage

// File: rtl/mmss_timer_ctrl_tick.sv
// One-second tick generator: counts clk cycles while enabled and pulses tick
// on the last count of each TICK_DIV-cycle period.
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmss_timer_ctrl.sv
// MM:SS run/pause/clear/load sequencer feeding the seven-segment display driver.
// Counts up as a stopwatch or down as a timer, one step per prescaler tick.
module mmss_timer_ctrl
  import mmss_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       mode_i,
  input  logic [5:0] load_min_i,
  input  logic [5:0] load_sec_i,
  output logic [5:0] min_o,
  output logic [5:0] sec_o,
  output logic       running_o,
  output logic       done_o
);

  state_t     state_q, state_d;
  logic [5:0] min_d, sec_d;
  logic       mode_q, mode_d;
  logic       done_d;
  logic       presc_clr;
  logic       tick;
  logic       start_eff;

  // Higher-priority commands in the same cycle swallow start_i.
  assign start_eff = start_i && !clr_i && !load_i;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == RUN),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    min_d     = min_o;
    sec_d     = sec_o;
    mode_d    = mode_q;
    done_d    = 1'b0;
    presc_clr = 1'b0;

    if (clr_i) begin
      state_d   = IDLE;
      min_d     = '0;
      sec_d     = '0;
      presc_clr = 1'b1;
    end else if (load_i && state_q != RUN) begin
      state_d   = IDLE;
      min_d     = clamp_ms(load_min_i);
      sec_d     = clamp_ms(load_sec_i);
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // A countdown from 00:00 would finish instantly, so refuse it.
          if (start_eff && !(mode_i == MODE_DOWN && min_o == '0 && sec_o == '0)) begin
            state_d   = RUN;
            mode_d    = mode_i;
            presc_clr = 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            if (mode_q == MODE_UP) begin
              if (sec_o != MAX_MS) begin
                sec_d = sec_o + 6'd1;
              end else if (min_o != MAX_MS) begin
                sec_d = '0;
                min_d = min_o + 6'd1;
              end
            end else begin
              if (sec_o != '0) begin
                sec_d = sec_o - 6'd1;
              end else if (min_o != '0) begin
                sec_d = MAX_MS;
                min_d = min_o - 6'd1;
              end
            end
          end
          // Reaching the end point wins over a simultaneous pause request.
          if (tick && ((mode_q == MODE_UP && min_d == MAX_MS && sec_d == MAX_MS) ||
                       (mode_q == MODE_DOWN && min_d == '0 && sec_d == '0))) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (start_eff) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start_eff) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      min_o     <= '0;
      sec_o     <= '0;
      mode_q    <= MODE_UP;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_o     <= min_d;
      sec_o     <= sec_d;
      mode_q    <= mode_d;
      running_o <= (state_d == RUN);
      done_o    <= done_d;
    end
  end

  a_time_range: assert property (@(posedge clk) disable iff (!rst_n)
    (min_o <= MAX_MS) && (sec_o <= MAX_MS));

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// Scoreboard bench for mmss_timer_ctrl: a seconds-based reference model
// predicts every cycle's outputs; a monitor compares them against the DUT.
module tb_mmss_timer_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0, clr_i = 1'b0, load_i = 1'b0, mode_i = 1'b0;
  logic [5:0] load_min_i = '0, load_sec_i = '0;
  logic [5:0] min_o, sec_o;
  logic       running_o, done_o;

  int tests = 0;
  int failed = 0;

  logic [13:0] exp_q[$];

  // Reference state: time is kept as total seconds.
  int m_st = 0, m_t = 0, m_p = 0;
  bit m_mode = 0, m_run = 0, m_done = 0;

  always #5 clk = ~clk;

  mmss_timer_ctrl #(.TICK_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .mode_i     (mode_i),
    .load_min_i (load_min_i),
    .load_sec_i (load_sec_i),
    .min_o      (min_o),
    .sec_o      (sec_o),
    .running_o  (running_o),
    .done_o     (done_o)
  );

  function automatic void model(input bit r, s, c, l, md, input int lm, ls);
    bit se, tk;
    if (!r) begin
      m_st = 0; m_t = 0; m_p = 0; m_mode = 0; m_run = 0; m_done = 0;
    end else begin
      se = s && !c && !l;
      m_done = 0;
      if (c) begin
        m_st = 0; m_t = 0; m_p = 0;
      end else if (l && m_st != 1) begin
        m_st = 0; m_p = 0;
        m_t = ((lm > 59) ? 59 : lm) * 60 + ((ls > 59) ? 59 : ls);
      end else begin
        case (m_st)
          0: if (se && !(md && m_t == 0)) begin
               m_st = 1; m_mode = md; m_p = 0;
             end
          1: begin
               tk = (m_p == DIV - 1);
               m_p = tk ? 0 : m_p + 1;
               if (tk) m_t = m_mode ? ((m_t > 0) ? m_t - 1 : 0) : ((m_t < 3599) ? m_t + 1 : 3599);
               if (tk && ((!m_mode && m_t == 3599) || (m_mode && m_t == 0))) begin
                 m_st = 3; m_done = 1;
               end else if (se) begin
                 m_st = 2;
               end
             end
          2: if (se) m_st = 1;
          default: ;
        endcase
      end
      m_run = (m_st == 1);
    end
    exp_q.push_back({6'(m_t / 60), 6'(m_t % 60), m_run, m_done});
  endfunction

  // Apply one cycle of inputs at the falling edge and predict the post-edge outputs.
  task automatic cyc(input bit r, s, c, l, md, input logic [5:0] lm, ls);
    @(negedge clk);
    rst_n = r; start_i = s; clr_i = c; load_i = l; mode_i = md;
    load_min_i = lm; load_sec_i = ls;
    model(r, s, c, l, md, int'(lm), int'(ls));
  endtask

  task automatic idle(input int n, input bit md);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, md, 6'd0, 6'd0);
  endtask

  initial begin : monitor
    logic [13:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({min_o, sec_o, running_o, done_o} !== e) begin
          failed++;
          $display("FAIL scoreboard t=%0t: got %0d:%0d run=%0b done=%0b, expected %0d:%0d run=%0b done=%0b",
                   $time, min_o, sec_o, running_o, done_o, e[13:8], e[7:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : stim
    bit r, s, c, l, md;
    logic [5:0] lm, ls;
    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 6'd0, 6'd0);
    idle(2, 0);
    // Stopwatch through 61 ticks, crossing into minute 1.
    cyc(1, 1, 0, 0, 0, 6'd0, 6'd0);
    idle(61 * DIV + 3, 0);
    // Countdown 00:02 to DONE, then starts ignored.
    cyc(1, 0, 1, 0, 0, 6'd0, 6'd0);
    cyc(1, 0, 0, 1, 1, 6'd0, 6'd2);
    cyc(1, 1, 0, 0, 1, 6'd0, 6'd0);
    idle(3 * DIV, 1);
    cyc(1, 1, 0, 0, 1, 6'd0, 6'd0);
    idle(2, 0);
    cyc(1, 1, 0, 0, 0, 6'd0, 6'd0);
    idle(DIV + 1, 0);
    // Pause and resume with held prescaler.
    cyc(1, 0, 0, 1, 0, 6'd3, 6'd10);
    cyc(1, 1, 0, 0, 0, 6'd0, 6'd0);
    idle(2, 0);
    cyc(1, 1, 0, 0, 1, 6'd0, 6'd0);
    idle(20, 1);
    cyc(1, 1, 0, 0, 1, 6'd0, 6'd0);
    idle(2 * DIV + 2, 1);
    // Clamped load, load during RUN, and all three commands together.
    cyc(1, 0, 0, 1, 0, 6'd63, 6'd45);
    cyc(1, 1, 0, 0, 0, 6'd0, 6'd0);
    idle(DIV, 0);
    cyc(1, 0, 0, 1, 0, 6'd5, 6'd5);
    idle(DIV, 0);
    cyc(1, 1, 1, 1, 0, 6'd12, 6'd34);
    idle(DIV, 0);
    // Up-count into 59:59, then refused countdown start at 00:00.
    cyc(1, 0, 0, 1, 0, 6'd59, 6'd58);
    cyc(1, 1, 0, 0, 0, 6'd0, 6'd0);
    idle(2 * DIV + 2, 0);
    cyc(1, 0, 1, 0, 1, 6'd0, 6'd0);
    cyc(1, 1, 0, 0, 1, 6'd0, 6'd0);
    idle(DIV, 1);
    // Randomized command streams.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 499) != 0);
      s  = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 59) == 0);
      l  = ($urandom_range(0, 29) == 0);
      md = ($urandom_range(0, 15) == 0) ? ~mode_i : mode_i;
      case ($urandom_range(0, 3))
        0: lm = 6'd0;
        1: lm = 6'(58 + $urandom_range(0, 5));
        default: lm = 6'($urandom_range(0, 63));
      endcase
      ls = ($urandom_range(0, 1) == 0) ? 6'(55 + $urandom_range(0, 8)) : 6'($urandom_range(0, 63));
      cyc(r, s, c, l, md, lm, ls);
    end
    idle(2, 0);
    @(posedge clk);
    #5;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
